// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and counter width helper for the systolic array
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/systolic_os_pe.sv
// systolic_os_pe: output-stationary MAC cell passing A right and B down
module systolic_os_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);
  logic [ACC_WIDTH-1:0] a_ext, b_ext;
  // extending operands to ACC_WIDTH first makes the low bits of the product correct for both signednesses
  always_comb begin
    a_ext = {{(ACC_WIDTH-DATA_WIDTH){SIGNED & a_in[DATA_WIDTH-1]}}, a_in};
    b_ext = {{(ACC_WIDTH-DATA_WIDTH){SIGNED & b_in[DATA_WIDTH-1]}}, b_in};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (enable) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + a_ext * b_ext;
    end
endmodule

// File: rtl/systolic_os_array.sv
// systolic_os_array: output-stationary ROWSxCOLS matrix multiply with internal skew, flush and drain
module systolic_os_array
  import systolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_K      = 256,
  parameter bit SIGNED     = 1'b1,
  localparam int KW        = $clog2(MAX_K+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [KW-1:0]              k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_vec,
  input  logic [COLS*DATA_WIDTH-1:0] b_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*ACC_WIDTH-1:0]  out_row,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);
  localparam int FW = cnt_w(ROWS+COLS-1);
  localparam int RW = cnt_w(ROWS);
  state_t state;
  logic [KW-1:0] k_lat, beat;
  logic [FW-1:0] fcnt;
  logic [RW-1:0] row;
  logic adv, clr;
  logic [DATA_WIDTH-1:0] a_h [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] b_v [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  acc [ROWS][COLS];
  assign clr       = state == IDLE && start;
  assign adv       = (state == FEED && in_valid) || state == FLUSH;
  assign in_ready  = state == FEED;
  assign busy      = state != IDLE;
  assign out_valid = state == DRAIN;
  assign out_last  = out_valid && row == RW'(ROWS-1);
  for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
    logic [DATA_WIDTH-1:0] src;
    assign src = state == FEED ? a_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign a_h[r][0] = src;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sr [r];
      always_ff @(posedge clk or posedge rst)
        if (rst || clr) sr <= '{default: '0};
        else if (adv) begin
          sr[0] <= src;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      assign a_h[r][0] = sr[r-1];
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_skew_b
    logic [DATA_WIDTH-1:0] src;
    assign src = state == FEED ? b_vec[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign b_v[0][c] = src;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sr [c];
      always_ff @(posedge clk or posedge rst)
        if (rst || clr) sr <= '{default: '0};
        else if (adv) begin
          sr[0] <= src;
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      assign b_v[0][c] = sr[c-1];
    end
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_os_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .enable(adv),
        .clear (clr),
        .a_in  (a_h[r][c]),
        .b_in  (b_v[r][c]),
        .a_out (a_h[r][c+1]),
        .b_out (b_v[r+1][c]),
        .acc   (acc[r][c])
      );
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign out_row[c*ACC_WIDTH +: ACC_WIDTH] = out_valid ? acc[row][c] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      k_lat <= '0;
      beat  <= '0;
      fcnt  <= '0;
      row   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          k_lat <= k_len;
          beat  <= '0;
          fcnt  <= '0;
          row   <= '0;
          state <= (k_len == '0) ? DRAIN : FEED;
        end
        FEED: if (in_valid) begin
          beat <= beat + 1'b1;
          if (beat == k_lat - 1'b1) state <= FLUSH;
        end
        FLUSH: begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == FW'(ROWS+COLS-2)) state <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          row <= row + 1'b1;
          if (row == RW'(ROWS-1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_systolic_os_array.sv
// tb_systolic_os_array: scoreboard bench for the signed 40-bit and unsigned 32-bit array variants
module tb_systolic_os_array;
  typedef struct {logic [159:0] row; logic last;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start0, in_valid0, in_ready0, out_valid0, out_ready0, out_last0, busy0, done0;
  logic [8:0] k_len0;
  logic [63:0] a_vec0, b_vec0;
  logic [159:0] out_row0;
  logic start1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1, done1;
  logic [8:0] k_len1;
  logic [63:0] a_vec1, b_vec1;
  logic [127:0] out_row1;
  int checks = 0, errors = 0, cyc = 0, done_cnt0 = 0, t_start = 0, t_done = 0;
  exp_t q0[$], q1[$];
  logic [15:0] ma [4][8];
  logic [15:0] mb [8][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  systolic_os_array u0 (
    .clk(clk), .rst(rst), .start(start0), .k_len(k_len0), .in_valid(in_valid0), .in_ready(in_ready0),
    .a_vec(a_vec0), .b_vec(b_vec0), .out_valid(out_valid0), .out_ready(out_ready0), .out_row(out_row0),
    .out_last(out_last0), .busy(busy0), .done(done0)
  );
  systolic_os_array #(.ACC_WIDTH(32), .SIGNED(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .k_len(k_len1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_vec(a_vec1), .b_vec(b_vec1), .out_valid(out_valid1), .out_ready(out_ready1), .out_row(out_row1),
    .out_last(out_last1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_row0: got %h want none", out_row0);
      end else begin
        e = q0.pop_front();
        chk("row0", out_row0, e.row);
        chk("last0", out_last0, e.last);
      end
    end
    if (done0) done_cnt0++;
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_row1: got %h want none", out_row1);
      end else begin
        e = q1.pop_front();
        chk("row1", out_row1, e.row);
        chk("last1", out_last1, e.last);
      end
    end
  end

  task automatic push_model0(input int k);
    for (int r = 0; r < 4; r++) begin
      exp_t e;
      e.row = '0;
      for (int c = 0; c < 4; c++) begin
        longint s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'($signed(ma[r][kk])) * longint'($signed(mb[kk][c]));
        e.row[c*40 +: 40] = s[39:0];
      end
      e.last = (r == 3);
      q0.push_back(e);
    end
  endtask

  task automatic do_start0(input int k);
    @(negedge clk);
    start0 = 1'b1; k_len0 = 9'(k); t_start = cyc;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic do_feed0(input int k, input bit stall);
    int kk = 0, g = 0;
    logic hs;
    while (kk < k && g < 2000) begin
      in_valid0 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int r = 0; r < 4; r++) a_vec0[r*16 +: 16] = in_valid0 ? ma[r][kk] : 16'($urandom);
      for (int c = 0; c < 4; c++) b_vec0[c*16 +: 16] = in_valid0 ? mb[kk][c] : 16'($urandom);
      hs = in_valid0 && in_ready0;
      @(negedge clk);
      if (hs) kk++;
      g++;
    end
    in_valid0 = 1'b0;
    if (kk < k) begin
      checks++; errors++;
      $display("FAIL feed_timeout: got %0d beats want %0d", kk, k);
    end
    chk("ready_low_after_last_beat", {busy0, in_ready0}, 2'b10);
  endtask

  task automatic do_drain0(input int bp_row, input int bp_cyc, input bit poke);
    int n = 0;
    logic [159:0] snap;
    while (!out_valid0 && n < 100) begin
      start0 = poke && n == 0; k_len0 = '0;
      @(negedge clk);
      n++;
    end
    start0 = 1'b0;
    chk("flush_latency", n, 7);
    for (int r = 0; r < 4; r++) begin
      if (r == bp_row) begin
        out_ready0 = 1'b0;
        snap = out_row0;
        repeat (bp_cyc) begin
          @(negedge clk);
          chk("bp_hold", {out_valid0, out_row0}, {1'b1, snap});
        end
        out_ready0 = 1'b1;
      end
      @(negedge clk);
    end
    t_done = cyc;
    chk("done_pulse", done0, 1'b1);
    @(negedge clk);
    chk("idle_after_done", {busy0, done0}, 2'b00);
  endtask

  task automatic job1(input int k, input logic [15:0] v, input logic [31:0] res);
    int kk = 0, g = 0, n = 0;
    logic hs;
    for (int r = 0; r < 4; r++) begin
      exp_t e;
      e.row = '0;
      for (int c = 0; c < 4; c++) e.row[c*32 +: 32] = res;
      e.last = (r == 3);
      q1.push_back(e);
    end
    a_vec1 = {4{v}}; b_vec1 = {4{v}};
    @(negedge clk);
    start1 = 1'b1; k_len1 = 9'(k);
    @(negedge clk);
    start1 = 1'b0;
    if (k == 0) chk("k0_immediate_drain", {busy1, out_valid1, in_ready1}, 3'b110);
    while (kk < k && g < 50) begin
      in_valid1 = 1'b1;
      hs = in_ready1;
      @(negedge clk);
      if (hs) kk++;
      g++;
    end
    in_valid1 = 1'b0;
    while (!done1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done1", done1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d;
    start0 = 0; k_len0 = 0; in_valid0 = 0; a_vec0 = 0; b_vec0 = 0; out_ready0 = 1;
    start1 = 0; k_len1 = 0; in_valid1 = 0; a_vec1 = 0; b_vec1 = 0; out_ready1 = 1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl0", {in_ready0, out_valid0, out_last0, busy0, done0}, 5'b0);
    chk("rst_row0", out_row0, '0);
    chk("rst_ctrl1", {in_ready1, out_valid1, out_last1, busy1, done1, out_row1}, '0);
    rst = 1'b0;
    // identity A, B[k][c] = 10k+c: rows of C equal rows of B
    for (int r = 0; r < 4; r++) for (int kk = 0; kk < 8; kk++) ma[r][kk] = 16'(r == kk);
    for (int kk = 0; kk < 8; kk++) for (int c = 0; c < 4; c++) mb[kk][c] = 16'(10*kk + c);
    for (int r = 0; r < 4; r++) begin
      exp_t e;
      for (int c = 0; c < 4; c++) e.row[c*40 +: 40] = 40'(10*r + c);
      e.last = (r == 3);
      q0.push_back(e);
    end
    d = done_cnt0;
    do_start0(4); do_feed0(4, 1'b0); do_drain0(-1, 0, 1'b0);
    chk("job_time", t_done - t_start, 16);
    chk("done_once_identity", done_cnt0 - d, 1);
    // all -2 times all 3 over K=3
    for (int r = 0; r < 4; r++) for (int kk = 0; kk < 8; kk++) ma[r][kk] = 16'hFFFE;
    for (int kk = 0; kk < 8; kk++) for (int c = 0; c < 4; c++) mb[kk][c] = 16'd3;
    for (int r = 0; r < 4; r++) q0.push_back('{row: {4{40'hFF_FFFF_FFEE}}, last: r == 3});
    do_start0(3); do_feed0(3, 1'b0); do_drain0(-1, 0, 1'b0);
    // random operands with input stalls
    for (int r = 0; r < 4; r++) for (int kk = 0; kk < 8; kk++) ma[r][kk] = 16'($urandom);
    for (int kk = 0; kk < 8; kk++) for (int c = 0; c < 4; c++) mb[kk][c] = 16'($urandom);
    push_model0(8);
    do_start0(8); do_feed0(8, 1'b1); do_drain0(-1, 0, 1'b0);
    // output backpressure on row 2
    for (int r = 0; r < 4; r++) for (int kk = 0; kk < 8; kk++) ma[r][kk] = 16'($urandom);
    push_model0(5);
    d = done_cnt0;
    do_start0(5); do_feed0(5, 1'b0); do_drain0(2, 5, 1'b0);
    chk("done_once_bp", done_cnt0 - d, 1);
    // abort mid-flush with large operands, then a clean identity job
    for (int r = 0; r < 4; r++) for (int kk = 0; kk < 8; kk++) ma[r][kk] = 16'd7;
    do_start0(4); do_feed0(4, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_async", {busy0, out_valid0, in_ready0}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) for (int kk = 0; kk < 8; kk++) ma[r][kk] = 16'(r == kk);
    for (int kk = 0; kk < 8; kk++) for (int c = 0; c < 4; c++) mb[kk][c] = 16'(10*kk + c);
    for (int r = 0; r < 4; r++) begin
      exp_t e;
      for (int c = 0; c < 4; c++) e.row[c*40 +: 40] = 40'(10*r + c);
      e.last = (r == 3);
      q0.push_back(e);
    end
    d = done_cnt0;
    do_start0(4); do_feed0(4, 1'b0); do_drain0(-1, 0, 1'b1);
    chk("done_once_after_abort", done_cnt0 - d, 1);
    // unsigned 32-bit wrap and zero-length job
    job1(2, 16'hFFFF, 32'hFFFC_0002);
    job1(0, 16'hFFFF, 32'h0);
    repeat (2) @(negedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_os_array.md
# systolic_os_array

Parametrised output-stationary systolic matrix-multiply engine with its own sequencing FSM. It computes C = A·B for an A of ROWS×K and a B of K×COLS, where K is set per job at run time. Operand skewing, flush and result drain are all handled internally, so no external delay lines are needed. It sits between the operand fetch buffers (upstream, valid/ready) and the result writeback (downstream, valid/ready).

## Interface
- ROWS, 4: array rows; ≥1.
- COLS, 4: array columns; ≥1.
- DATA_WIDTH, 16: operand width.
- ACC_WIDTH, 40: accumulator and result width; ≥2·DATA_WIDTH.
- MAX_K, 256: largest inner dimension; the k_len port is $clog2(MAX_K+1) bits wide.
- SIGNED, 1: 1 selects two's-complement operands, 0 selects unsigned.

Ports:
- clk  in  1  the single clock.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  job start pulse; accepted only in IDLE.
- k_len  in  KW  inner dimension K, sampled on an accepted start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat ready.
- a_vec  in  ROWS·DATA_WIDTH  one column k of A; element r sits at [r·DATA_WIDTH +: DATA_WIDTH].
- b_vec  in  COLS·DATA_WIDTH  one row k of B; element c sits at [c·DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result row valid.
- out_ready  in  1  result row accepted.
- out_row  out  COLS·ACC_WIDTH  row r of C; element c sits at [c·ACC_WIDTH +: ACC_WIDTH].
- out_last  out  1  asserted with the final row (r = ROWS-1).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the cycle after the last row handshake.

## Operation
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE → FEED on start.
  - Accumulators, skew registers and PE operand registers all clear to 0 on that edge.
  - k_len is latched at the same edge.
- IDLE → DRAIN directly if start arrives with k_len = 0. All ROWS rows then drain as zeros.
- start outside IDLE is ignored and has no side effects.
- FEED:
  - in_ready = 1.
  - On each beat where in_valid and in_ready are both high, the skew stage, the array and the beat counter all advance by one step.
  - With no handshake, the whole datapath holds; a stall is not a bubble.
  - After the K-th beat, the FSM moves to FLUSH.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles.
  - The datapath advances every cycle and zeros are injected at the skewed inputs.
  - Then moves to DRAIN.
- Skew: row r of A is delayed r steps and column c of B is delayed c steps. A operands move right and B operands move down, one PE per step.
- PE(r,c) MAC: acc ← acc + a·b.
  - The product is the 2·DATA_WIDTH-bit product, sign- or zero-extended (per SIGNED) to ACC_WIDTH.
  - The sum wraps modulo 2^ACC_WIDTH, with no saturation.
- DRAIN:
  - out_row is driven from the accumulators of row r, with r starting at 0.
  - out_valid = 1 throughout DRAIN.
  - r increments on each out_valid && out_ready handshake.
  - out_row and out_valid stay stable while out_ready = 0.
  - After the handshake on row ROWS-1, the FSM returns to IDLE and pulses done.
- When rst is asserted at any point, including mid-job, all state returns to reset values immediately. Any partial job is discarded.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0, out_last = 0, busy = 0, done = 0.
  - out_row = 0, all accumulators = 0, FSM in IDLE.
- Start to ready: start is seen in IDLE at edge t. busy and in_ready are high from t+1.
- Feed to results: the K-th beat is accepted at edge f. out_valid rises at edge f+ROWS+COLS-1 (the first DRAIN cycle).
- Minimum job length with no stalls: 1 + K + (ROWS+COLS-1) + ROWS cycles from start to done.
- in_ready and out_valid are registered-state decodes. They never depend combinationally on in_valid or out_ready.

## Structure
- systolic_pkg holds:
  - the state enum state_t {IDLE, FEED, FLUSH, DRAIN};
  - a clog2-based width helper for the counters.
- Sub-module systolic_os_pe, one per array position:
  - inputs: enable, clear, a_in, b_in;
  - outputs: a_out, b_out, acc;
  - both operand registers and the accumulator sit behind enable.
- Top-level contents:
  - the skew shift registers, generated per lane with delay = lane index and gated by the datapath advance;
  - the FSM;
  - the beat counter, flush counter and drain counter;
  - the output row mux.

## Test plan
- Identity, ROWS=COLS=4, K=4, SIGNED=1: A = I and B[k][c] = 10k+c. The drained rows must equal B. out_last on row 3, done one cycle later, total job time 16 cycles with no stalls.
- Signed arithmetic, K=3: every A element = -2 and every B element = 3. Every C element must be -18 (0xFF_FFFF_FFEE at ACC_WIDTH=40).
- Input stalls: K=8 with in_valid deasserted on a random ~50% of cycles. Results must match the golden model exactly, and FLUSH starts only after the 8th handshake.
- Output backpressure: out_ready held low for 5 cycles on row 2. out_row must stay constant throughout, no row may be skipped or duplicated, and done pulses exactly once.
- Wrap and edge cases, ACC_WIDTH=32, DATA_WIDTH=16, SIGNED=0:
  - K=2 with all operands 0xFFFF: result must be 0xFFFC0002 (2·0xFFFE0001 mod 2^32);
  - k_len=0: four rows of zeros immediately after start.
- Reset and protocol: rst asserted mid-FLUSH must force busy=0 and out_valid=0 at once. The following job must produce results untainted by the aborted one. A start during busy must be ignored.
